io_port_ctrl: RTL and testbench
===============================

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter D_WIDTH, default 34, SHALL set the I/O data width.
REQ-002 Parameter PA_WIDTH, default 4, SHALL set the port address width.
REQ-003 Parameter TO_WIDTH, default 8, SHALL set the timeout counter width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock.
- reset_i  in  1  synchronous active-high reset.
REQ-005 Backend-side ports SHALL be:
- in_start_i  in  1  one-cycle pulse: start an input transfer.
- out_start_i  in  1  one-cycle pulse: start an output transfer.
- port_addr_i  in  PA_WIDTH  target port, sampled at start.
- wr_data_i  in  D_WIDTH  output data, sampled at start.
- busy_o  out  1  transfer in progress; backend stalls dequeue.
- done_o  out  1  one-cycle completion pulse.
- timeout_o  out  1  one-cycle pulse, coincident with done_o on timeout.
- rd_data_o  out  D_WIDTH  last captured input data.
REQ-006 I/O-side ports SHALL be:
- in_req_o  out  1  input request.
- out_req_o  out  1  output request.
- in_addr_o  out  PA_WIDTH  input port address.
- out_addr_o  out  PA_WIDTH  output port address.
- out_data_o  out  D_WIDTH  output data.
- in_data_i  in  D_WIDTH  input data, valid with in_ack_i.
- in_ack_i  in  1  input acknowledge.
- out_ack_i  in  1  output acknowledge.

Function
REQ-007 The FSM SHALL have exactly four states: IDLE, IN_WAIT, OUT_WAIT, DONE.
REQ-008 In IDLE with in_start_i=1, the FSM SHALL go to IN_WAIT and latch port_addr_i.
REQ-009 In IDLE with out_start_i=1 and in_start_i=0, the FSM SHALL go to OUT_WAIT and latch port_addr_i and wr_data_i.
REQ-010 If in_start_i and out_start_i are both 1 in IDLE, input SHALL win and out_start_i SHALL be dropped; the requester reissues it.
REQ-011 Start pulses outside IDLE SHALL be ignored, with no queuing.
REQ-012 in_req_o SHALL be 1 in every cycle of IN_WAIT and 0 otherwise. out_req_o SHALL be 1 in every cycle of OUT_WAIT and 0 otherwise. Both are registered, so a request rises the cycle after the start pulse.
REQ-013 The address and data outputs SHALL hold their latched values, stable for the whole request.
REQ-014 In IN_WAIT, on in_ack_i=1, the block SHALL capture in_data_i into rd_data_o and go to DONE.
REQ-015 In OUT_WAIT, on out_ack_i=1, the FSM SHALL go to DONE.
REQ-016 An acknowledge arriving in the first request cycle SHALL be honoured, giving a minimum start-to-done_o latency of 2 cycles.
REQ-017 Acknowledges in IDLE or DONE, and an acknowledge for the non-active direction, SHALL be ignored.
REQ-018 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE. A new start pulse is accepted the cycle after DONE.
REQ-019 busy_o SHALL be 1 in IN_WAIT, OUT_WAIT and DONE, and 0 in IDLE.
REQ-020 rd_data_o SHALL hold its value until the next successful input capture; output transfers and timeouts leave it unchanged.

Reset
REQ-021 When reset_i=1 at a clock edge, the block SHALL enter IDLE and clear all of the following:
- outputs: in_req_o, out_req_o, busy_o, done_o, timeout_o, the address outputs, out_data_o and rd_data_o;
- the timeout counter.
REQ-022 Reset mid-transfer SHALL abort the transfer with no done_o pulse. An acknowledge in the same cycle as reset SHALL be discarded.

Configuration
REQ-023 When macro IO_PORT_CTRL_TIMEOUT_EN is defined, the counter and timeout behaviour SHALL be:
- counter clears on entry to IN_WAIT or OUT_WAIT, then increments once per WAIT cycle;
- if it reaches 2^TO_WIDTH-1 with no acknowledge, the next state is DONE with timeout_o=1 and rd_data_o unchanged;
- an acknowledge in that same cycle takes priority, giving a normal completion.
REQ-024 When IO_PORT_CTRL_TIMEOUT_EN is undefined, the WAIT states SHALL wait indefinitely, and timeout_o SHALL be tied to 0 with no counter logic.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- in_start_i pulse, port_addr_i=4'h3; in_data_i=34'h1_2345_6789 with in_ack_i on the 3rd request cycle -> in_req_o high 3 cycles, in_addr_o=3, done_o pulse, rd_data_o=34'h1_2345_6789.
- out_start_i pulse, port_addr_i=4'hA, wr_data_i=34'h0_0000_00FF; out_ack_i in the 1st request cycle -> out_req_o high 1 cycle, out_addr_o=A, out_data_o=FF, done_o 2 cycles after start.
- in_start_i and out_start_i together -> only in_req_o asserts; out_req_o stays 0 throughout.
- Start pulse while busy_o=1, plus a stray out_ack_i in IDLE -> both ignored, with no state change.
- reset_i during OUT_WAIT -> out_req_o=0 and busy_o=0 on the next cycle, with no done_o.
- With IO_PORT_CTRL_TIMEOUT_EN and TO_WIDTH=4, no acknowledge -> done_o and timeout_o pulse 16 cycles after the request rises, rd_data_o unchanged. Without the macro -> the request stays high past 100 cycles.

Source files
------------

// File: rtl/io_port_ctrl.sv
// Single-transfer I/O port controller: runs one input or one output handshake at a time.
// Optional watchdog on the WAIT states is enabled by defining IO_PORT_CTRL_TIMEOUT_EN.
module io_port_ctrl #(
  parameter int D_WIDTH  = 34,
  parameter int PA_WIDTH = 4,
  parameter int TO_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                in_start_i,
  input  logic                out_start_i,
  input  logic [PA_WIDTH-1:0] port_addr_i,
  input  logic [D_WIDTH-1:0]  wr_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [D_WIDTH-1:0]  rd_data_o,
  output logic                in_req_o,
  output logic                out_req_o,
  output logic [PA_WIDTH-1:0] in_addr_o,
  output logic [PA_WIDTH-1:0] out_addr_o,
  output logic [D_WIDTH-1:0]  out_data_o,
  input  logic [D_WIDTH-1:0]  in_data_i,
  input  logic                in_ack_i,
  input  logic                out_ack_i
);

  typedef enum logic [1:0] {IDLE, IN_WAIT, OUT_WAIT, DONE} state_t;

  state_t state;

`ifdef IO_PORT_CTRL_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt;
  logic                to_hit;

  assign to_hit = (to_cnt == {TO_WIDTH{1'b1}});
`else
  assign timeout_o = 1'b0;
`endif

  // Input start wins over output start; a simultaneous output start is dropped.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= IDLE;
      in_req_o   <= 1'b0;
      out_req_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      in_addr_o  <= '0;
      out_addr_o <= '0;
      out_data_o <= '0;
      rd_data_o  <= '0;
`ifdef IO_PORT_CTRL_TIMEOUT_EN
      to_cnt     <= '0;
      timeout_o  <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef IO_PORT_CTRL_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_start_i) begin
            state     <= IN_WAIT;
            in_req_o  <= 1'b1;
            busy_o    <= 1'b1;
            in_addr_o <= port_addr_i;
`ifdef IO_PORT_CTRL_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end else if (out_start_i) begin
            state      <= OUT_WAIT;
            out_req_o  <= 1'b1;
            busy_o     <= 1'b1;
            out_addr_o <= port_addr_i;
            out_data_o <= wr_data_i;
`ifdef IO_PORT_CTRL_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        IN_WAIT: begin
          if (in_ack_i) begin
            rd_data_o <= in_data_i;
            in_req_o  <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end
`ifdef IO_PORT_CTRL_TIMEOUT_EN
          else if (to_hit) begin
            in_req_o  <= 1'b0;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        OUT_WAIT: begin
          if (out_ack_i) begin
            out_req_o <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end
`ifdef IO_PORT_CTRL_TIMEOUT_EN
          else if (to_hit) begin
            out_req_o <= 1'b0;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed vector bench for io_port_ctrl; each vector is one clock with post-edge expectations.
module tb_io_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        in_start_i, out_start_i;
  logic [3:0]  port_addr_i;
  logic [33:0] wr_data_i;
  logic        busy_o, done_o, timeout_o;
  logic [33:0] rd_data_o;
  logic        in_req_o, out_req_o;
  logic [3:0]  in_addr_o, out_addr_o;
  logic [33:0] out_data_o;
  logic [33:0] in_data_i;
  logic        in_ack_i, out_ack_i;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic        rst, ist, ost;
    logic [3:0]  pa;
    logic [33:0] wd;
    logic        iack, oack;
    logic [33:0] id;
    logic        e_busy, e_done, e_to, e_ireq, e_oreq;
    logic [3:0]  e_iaddr, e_oaddr;
    logic [33:0] e_odata, e_rd;
  } vec_t;

  vec_t vecs[$];

  io_port_ctrl #(.D_WIDTH(34), .PA_WIDTH(4), .TO_WIDTH(4)) dut (
    .clk(clk), .reset_i(reset_i),
    .in_start_i(in_start_i), .out_start_i(out_start_i),
    .port_addr_i(port_addr_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .rd_data_o(rd_data_o),
    .in_req_o(in_req_o), .out_req_o(out_req_o),
    .in_addr_o(in_addr_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
    .in_data_i(in_data_i), .in_ack_i(in_ack_i), .out_ack_i(out_ack_i)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic rst, logic ist, logic ost, logic [3:0] pa,
                              logic [33:0] wd, logic iack, logic oack, logic [33:0] id,
                              logic b, logic d, logic ir, logic orq, logic [3:0] ia,
                              logic [3:0] oa, logic [33:0] od, logic [33:0] rd);
    vec_t v;
    v.name = n; v.rst = rst; v.ist = ist; v.ost = ost; v.pa = pa; v.wd = wd;
    v.iack = iack; v.oack = oack; v.id = id;
    v.e_busy = b; v.e_done = d; v.e_to = 1'b0; v.e_ireq = ir; v.e_oreq = orq;
    v.e_iaddr = ia; v.e_oaddr = oa; v.e_odata = od; v.e_rd = rd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset_i     = v.rst;
    in_start_i  = v.ist;
    out_start_i = v.ost;
    port_addr_i = v.pa;
    wr_data_i   = v.wd;
    in_ack_i    = v.iack;
    out_ack_i   = v.oack;
    in_data_i   = v.id;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [80:0] act, exp;
    act = {busy_o, done_o, timeout_o, in_req_o, out_req_o, in_addr_o, out_addr_o, out_data_o, rd_data_o};
    exp = {v.e_busy, v.e_done, v.e_to, v.e_ireq, v.e_oreq, v.e_iaddr, v.e_oaddr, v.e_odata, v.e_rd};
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got busy/done/to/ireq/oreq/ia/oa/od/rd=%b%b%b%b%b/%h/%h/%h/%h expected %b%b%b%b%b/%h/%h/%h/%h",
               v.name, busy_o, done_o, timeout_o, in_req_o, out_req_o, in_addr_o, out_addr_o,
               out_data_o, rd_data_o, v.e_busy, v.e_done, v.e_to, v.e_ireq, v.e_oreq,
               v.e_iaddr, v.e_oaddr, v.e_odata, v.e_rd);
    end
  endtask

  localparam logic [33:0] RD1 = 34'h1_2345_6789;
  localparam logic [33:0] RD2 = 34'h2_AAAA_5555;

  initial begin
    vec_t v;
    reset_i = 1'b1; in_start_i = 1'b0; out_start_i = 1'b0; port_addr_i = '0;
    wr_data_i = '0; in_ack_i = 1'b0; out_ack_i = 1'b0; in_data_i = '0;

    //           name              rst ist ost pa    wd              iack oack id                b  d  ir or ia    oa    od              rd
    vecs.push_back(mk("reset",        1, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'h0, 4'h0, 34'h0,           34'h0));
    vecs.push_back(mk("in_start",     0, 1, 0, 4'h3, 34'h0,           0, 0, 34'h0,           1, 0, 1, 0, 4'h3, 4'h0, 34'h0,           34'h0));
    vecs.push_back(mk("in_wait2",     0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           1, 0, 1, 0, 4'h3, 4'h0, 34'h0,           34'h0));
    vecs.push_back(mk("in_wait3",     0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0_DEAD_BEEF, 1, 0, 1, 0, 4'h3, 4'h0, 34'h0,           34'h0));
    vecs.push_back(mk("in_ack",       0, 0, 0, 4'h0, 34'h0,           1, 0, RD1,             1, 1, 0, 0, 4'h3, 4'h0, 34'h0,           RD1));
    vecs.push_back(mk("idle1",        0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'h3, 4'h0, 34'h0,           RD1));
    vecs.push_back(mk("out_start",    0, 0, 1, 4'hA, 34'h0_0000_00FF, 0, 0, 34'h0,           1, 0, 0, 1, 4'h3, 4'hA, 34'h0_0000_00FF, RD1));
    vecs.push_back(mk("out_ack",      0, 0, 0, 4'h0, 34'h0,           0, 1, 34'h0,           1, 1, 0, 0, 4'h3, 4'hA, 34'h0_0000_00FF, RD1));
    vecs.push_back(mk("idle2",        0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'h3, 4'hA, 34'h0_0000_00FF, RD1));
    vecs.push_back(mk("both_start",   0, 1, 1, 4'h5, 34'h3_0000_0001, 0, 0, 34'h0,           1, 0, 1, 0, 4'h5, 4'hA, 34'h0_0000_00FF, RD1));
    vecs.push_back(mk("wrong_ack",    0, 0, 0, 4'h0, 34'h0,           0, 1, 34'h0,           1, 0, 1, 0, 4'h5, 4'hA, 34'h0_0000_00FF, RD1));
    vecs.push_back(mk("in_ack2",      0, 0, 0, 4'h0, 34'h0,           1, 0, RD2,             1, 1, 0, 0, 4'h5, 4'hA, 34'h0_0000_00FF, RD2));
    vecs.push_back(mk("idle3",        0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'h5, 4'hA, 34'h0_0000_00FF, RD2));
    vecs.push_back(mk("stray_ack",    0, 0, 0, 4'h0, 34'h0,           1, 1, 34'h3_FFFF_FFFF, 0, 0, 0, 0, 4'h5, 4'hA, 34'h0_0000_00FF, RD2));
    vecs.push_back(mk("out_start2",   0, 0, 1, 4'h7, 34'h0_0000_0155, 0, 0, 34'h0,           1, 0, 0, 1, 4'h5, 4'h7, 34'h0_0000_0155, RD2));
    vecs.push_back(mk("in_st_busy",   0, 1, 0, 4'h9, 34'h0,           0, 0, 34'h0,           1, 0, 0, 1, 4'h5, 4'h7, 34'h0_0000_0155, RD2));
    vecs.push_back(mk("out_st_busy",  0, 0, 1, 4'h2, 34'h0_0000_0999, 0, 0, 34'h0,           1, 0, 0, 1, 4'h5, 4'h7, 34'h0_0000_0155, RD2));
    vecs.push_back(mk("out_ack2",     0, 0, 0, 4'h0, 34'h0,           1, 1, 34'h1_1111_1111, 1, 1, 0, 0, 4'h5, 4'h7, 34'h0_0000_0155, RD2));
    vecs.push_back(mk("st_in_done",   0, 1, 0, 4'h4, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'h5, 4'h7, 34'h0_0000_0155, RD2));
    vecs.push_back(mk("no_queue",     0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'h5, 4'h7, 34'h0_0000_0155, RD2));
    vecs.push_back(mk("out_start3",   0, 0, 1, 4'h1, 34'h2_0000_0000, 0, 0, 34'h0,           1, 0, 0, 1, 4'h5, 4'h1, 34'h2_0000_0000, RD2));
    vecs.push_back(mk("reset_mid",    1, 0, 0, 4'h0, 34'h0,           0, 1, 34'h0,           0, 0, 0, 0, 4'h0, 4'h0, 34'h0,           34'h0));
    vecs.push_back(mk("post_reset",   0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'h0, 4'h0, 34'h0,           34'h0));
    vecs.push_back(mk("in_start_min", 0, 1, 0, 4'hF, 34'h0,           0, 0, 34'h0,           1, 0, 1, 0, 4'hF, 4'h0, 34'h0,           34'h0));
    vecs.push_back(mk("in_ack_min",   0, 0, 0, 4'h0, 34'h0,           1, 0, 34'h0_0000_0001, 1, 1, 0, 0, 4'hF, 4'h0, 34'h0,           34'h1));
    vecs.push_back(mk("idle4",        0, 0, 0, 4'h0, 34'h0,           0, 0, 34'h0,           0, 0, 0, 0, 4'hF, 4'h0, 34'h0,           34'h1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Stalled input transfer: watchdog expiry or indefinite wait depending on build
    v = mk("stall_start", 0, 1, 0, 4'h6, 34'h0, 0, 0, 34'h0, 1, 0, 1, 0, 4'h6, 4'h0, 34'h0, 34'h1);
    applyStimulus(v);
    checkOutput(v);
`ifdef IO_PORT_CTRL_TIMEOUT_EN
    v = mk("stall_wait", 0, 0, 0, 4'h0, 34'h0, 0, 0, 34'h0_ABCD_0000, 1, 0, 1, 0, 4'h6, 4'h0, 34'h0, 34'h1);
    for (int c = 1; c < 16; c++) begin
      applyStimulus(v);
      checkOutput(v);
    end
    v = mk("timeout", 0, 0, 0, 4'h0, 34'h0, 0, 0, 34'h0_ABCD_0000, 1, 1, 0, 0, 4'h6, 4'h0, 34'h0, 34'h1);
    v.e_to = 1'b1;
    applyStimulus(v);
    checkOutput(v);
    v = mk("after_timeout", 0, 0, 0, 4'h0, 34'h0, 0, 0, 34'h0, 0, 0, 0, 0, 4'h6, 4'h0, 34'h0, 34'h1);
    applyStimulus(v);
    checkOutput(v);
`else
    v = mk("stall_wait", 0, 0, 0, 4'h0, 34'h0, 0, 0, 34'h0_ABCD_0000, 1, 0, 1, 0, 4'h6, 4'h0, 34'h0, 34'h1);
    for (int c = 1; c < 120; c++) begin
      applyStimulus(v);
      checkOutput(v);
    end
    v = mk("stall_reset", 1, 0, 0, 4'h0, 34'h0, 0, 0, 34'h0, 0, 0, 0, 0, 4'h0, 4'h0, 34'h0, 34'h0);
    applyStimulus(v);
    checkOutput(v);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
